// File: rtl/snake_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : snake_game_ctrl                                            |
// | Brief    : Snake game flow FSM: heading control, step timing, wall   |
// |            look-ahead, food scoring and grow pulses.                  |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module snake_game_ctrl #(
   parameter int STEP_PERIOD = 4,
   parameter int STEP_SIZE   = 4,
   parameter int X_MIN       = 2,
   parameter int X_MAX       = 639,
   parameter int Y_MIN       = 2,
   parameter int Y_MAX       = 479,
   parameter int SCORE_W     = 8
) (
   input  logic               frame_clk,
   input  logic               Reset,
   input  logic [7:0]         keycode,
   input  logic [9:0]         head_x,
   input  logic [9:0]         head_y,
   input  logic [9:0]         head_s,
   input  logic               food_hit,
   output logic [1:0]         state,
   output logic [1:0]         dir,
   output logic               step,
   output logic [9:0]         motion_x,
   output logic [9:0]         motion_y,
   output logic               grow,
   output logic [SCORE_W-1:0] score,
   output logic               game_over
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DEAD = 2'd2
   } state_t;

   localparam logic [1:0] c_DIR_RIGHT = 2'd0;
   localparam logic [1:0] c_DIR_LEFT  = 2'd1;
   localparam logic [1:0] c_DIR_DOWN  = 2'd2;
   localparam logic [1:0] c_DIR_UP    = 2'd3;

   localparam logic [7:0] c_KEY_A     = 8'h04;
   localparam logic [7:0] c_KEY_D     = 8'h07;
   localparam logic [7:0] c_KEY_S     = 8'h16;
   localparam logic [7:0] c_KEY_W     = 8'h1A;
   localparam logic [7:0] c_KEY_SPACE = 8'h2C;

   localparam int                 c_CNT_W    = $clog2(STEP_PERIOD);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STEP_PERIOD - 1);

   localparam logic signed [11:0] c_STEP  = 12'(STEP_SIZE);
   localparam logic signed [11:0] c_X_MIN = 12'(X_MIN);
   localparam logic signed [11:0] c_X_MAX = 12'(X_MAX);
   localparam logic signed [11:0] c_Y_MIN = 12'(Y_MIN);
   localparam logic signed [11:0] c_Y_MAX = 12'(Y_MAX);
   localparam logic [9:0]         c_POS   = 10'(STEP_SIZE);
   localparam logic [9:0]         c_NEG   = 10'(-STEP_SIZE);
   localparam logic [SCORE_W-1:0] c_SCORE_MAX = {SCORE_W{1'b1}};

   state_t               r_state,  w_state_nxt;
   logic [1:0]           r_dir,    w_dir_nxt;
   logic [1:0]           r_pend,   w_pend_nxt;
   logic                 r_step,   w_step_nxt;
   logic [9:0]           r_mx,     w_mx_nxt;
   logic [9:0]           r_my,     w_my_nxt;
   logic                 r_grow,   w_grow_nxt;
   logic [SCORE_W-1:0]   r_score,  w_score_nxt;
   logic                 r_go,     w_go_nxt;
   logic [c_CNT_W-1:0]   r_cnt,    w_cnt_nxt;
   logic                 r_hit_d;

   logic                 w_key_ok;
   logic [1:0]           w_key_dir;
   logic                 w_food_rise;
   logic                 w_due;
   logic                 w_fatal;
   logic [1:0]           w_ref_dir;
   logic signed [11:0]   w_hx, w_hy, w_hs;
   logic signed [11:0]   w_next, w_lo, w_hi;
   logic [9:0]           w_dx, w_dy;

   always_comb begin
      w_key_ok  = 1'b1;
      w_key_dir = c_DIR_RIGHT;
      case (keycode)
         c_KEY_D: w_key_dir = c_DIR_RIGHT;
         c_KEY_A: w_key_dir = c_DIR_LEFT;
         c_KEY_S: w_key_dir = c_DIR_DOWN;
         c_KEY_W: w_key_dir = c_DIR_UP;
         default: w_key_ok  = 1'b0;
      endcase
   end

   assign w_hx        = {2'b00, head_x};
   assign w_hy        = {2'b00, head_y};
   assign w_hs        = {2'b00, head_s};
   assign w_food_rise = food_hit & ~r_hit_d;
   assign w_due       = (r_state == S_RUN) && (r_cnt == c_CNT_LAST);

   // Look-ahead: where the head would land if the pending heading were stepped now
   always_comb begin
      w_next = w_hx + c_STEP;
      w_lo   = c_X_MIN;
      w_hi   = c_X_MAX;
      w_dx   = c_POS;
      w_dy   = 10'd0;
      case (r_pend)
         c_DIR_RIGHT: begin
            w_next = w_hx + c_STEP;
            w_dx   = c_POS;
         end
         c_DIR_LEFT: begin
            w_next = w_hx - c_STEP;
            w_dx   = c_NEG;
         end
         c_DIR_DOWN: begin
            w_next = w_hy + c_STEP;
            w_lo   = c_Y_MIN;
            w_hi   = c_Y_MAX;
            w_dx   = 10'd0;
            w_dy   = c_POS;
         end
         default: begin
            w_next = w_hy - c_STEP;
            w_lo   = c_Y_MIN;
            w_hi   = c_Y_MAX;
            w_dx   = 10'd0;
            w_dy   = c_NEG;
         end
      endcase
   end

   assign w_fatal   = ((w_next + w_hs) >= w_hi) || ((w_next - w_hs) <= w_lo);
   // On a step edge the new heading is the pending one, so legality is judged against it
   assign w_ref_dir = (w_due && !w_fatal) ? r_pend : r_dir;

   always_comb begin
      w_state_nxt = r_state;
      w_dir_nxt   = r_dir;
      w_pend_nxt  = r_pend;
      w_step_nxt  = 1'b0;
      w_mx_nxt    = r_mx;
      w_my_nxt    = r_my;
      w_grow_nxt  = 1'b0;
      w_score_nxt = r_score;
      w_go_nxt    = r_go;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            w_mx_nxt  = 10'd0;
            w_my_nxt  = 10'd0;
            if (w_key_ok) begin
               w_dir_nxt   = w_key_dir;
               w_pend_nxt  = w_key_dir;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_key_ok && (w_key_dir[1] != w_ref_dir[1])) begin
               w_pend_nxt = w_key_dir;
            end
            if (w_due) begin
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + c_CNT_W'(1);
            end
            if (w_due && w_fatal) begin
               w_state_nxt = S_DEAD;
               w_go_nxt    = 1'b1;
               w_mx_nxt    = 10'd0;
               w_my_nxt    = 10'd0;
            end else begin
               if (w_due) begin
                  w_step_nxt = 1'b1;
                  w_dir_nxt  = r_pend;
                  w_mx_nxt   = w_dx;
                  w_my_nxt   = w_dy;
               end
               if (w_food_rise) begin
                  w_grow_nxt = 1'b1;
                  if (r_score != c_SCORE_MAX) begin
                     w_score_nxt = r_score + SCORE_W'(1);
                  end
               end
            end
         end
         S_DEAD: begin
            w_cnt_nxt = '0;
            w_mx_nxt  = 10'd0;
            w_my_nxt  = 10'd0;
            if (keycode == c_KEY_SPACE) begin
               w_state_nxt = S_IDLE;
               w_score_nxt = '0;
               w_go_nxt    = 1'b0;
               w_dir_nxt   = c_DIR_RIGHT;
               w_pend_nxt  = c_DIR_RIGHT;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_dir   <= c_DIR_RIGHT;
         r_pend  <= c_DIR_RIGHT;
         r_step  <= 1'b0;
         r_mx    <= 10'd0;
         r_my    <= 10'd0;
         r_grow  <= 1'b0;
         r_score <= '0;
         r_go    <= 1'b0;
         r_cnt   <= '0;
         r_hit_d <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dir   <= w_dir_nxt;
         r_pend  <= w_pend_nxt;
         r_step  <= w_step_nxt;
         r_mx    <= w_mx_nxt;
         r_my    <= w_my_nxt;
         r_grow  <= w_grow_nxt;
         r_score <= w_score_nxt;
         r_go    <= w_go_nxt;
         r_cnt   <= w_cnt_nxt;
         r_hit_d <= food_hit;
      end
   end

   assign state     = r_state;
   assign dir       = r_dir;
   assign step      = r_step;
   assign motion_x  = r_mx;
   assign motion_y  = r_my;
   assign grow      = r_grow;
   assign score     = r_score;
   assign game_over = r_go;

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_snake_game_ctrl                                         |
// | Brief    : Randomized bench for snake_game_ctrl with a game-rule model|
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_snake_game_ctrl;

   localparam int P  = 4;
   localparam int SS = 4;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic [7:0] keycode;
   logic [9:0] head_x, head_y, head_s;
   logic       food_hit;

   logic [1:0] state, dir;
   logic       step, grow, game_over;
   logic [9:0] motion_x, motion_y;
   logic [7:0] score;

   logic [1:0] state2, dir2;
   logic       step2, grow2, game_over2;
   logic [9:0] motion_x2, motion_y2;
   logic [1:0] score2;

   int total = 0;
   int bad   = 0;

   // game-rule model
   int m_state, m_dir, m_pend, m_age, m_step, m_mx, m_my;
   int m_grow, m_score, m_score2, m_go, m_prev_hit;

   snake_game_ctrl dut (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
      .head_x(head_x), .head_y(head_y), .head_s(head_s), .food_hit(food_hit),
      .state(state), .dir(dir), .step(step), .motion_x(motion_x),
      .motion_y(motion_y), .grow(grow), .score(score), .game_over(game_over)
   );

   snake_game_ctrl #(.SCORE_W(2)) dut2 (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
      .head_x(head_x), .head_y(head_y), .head_s(head_s), .food_hit(food_hit),
      .state(state2), .dir(dir2), .step(step2), .motion_x(motion_x2),
      .motion_y(motion_y2), .grow(grow2), .score(score2), .game_over(game_over2)
   );

   always #5 frame_clk = ~frame_clk;

   function automatic int key_dir(input logic [7:0] k);
      case (k)
         8'h07:   return 0;
         8'h04:   return 1;
         8'h16:   return 2;
         8'h1A:   return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [36:0] got_vec();
      return {state, dir, step, motion_x, motion_y, grow, score, game_over, score2};
   endfunction

   function automatic logic [36:0] exp_vec();
      return {m_state[1:0], m_dir[1:0], m_step[0], m_mx[9:0], m_my[9:0],
              m_grow[0], m_score[7:0], m_go[0], m_score2[1:0]};
   endfunction

   task automatic model_reset();
      m_state = 0; m_dir = 0; m_pend = 0; m_age = 0; m_step = 0; m_mx = 0;
      m_my = 0; m_grow = 0; m_score = 0; m_score2 = 0; m_go = 0; m_prev_hit = 0;
   endtask

   // Applies the game rules for one frame edge using the inputs currently driven
   task automatic model_edge();
      int kd, pos, lo, hi, hs, ref_dir;
      bit due, fatal;
      kd = key_dir(keycode);
      hs = int'(head_s);
      m_step = 0;
      m_grow = 0;
      case (m_state)
         0: begin
            m_mx = 0; m_my = 0;
            if (kd >= 0) begin
               m_dir = kd; m_pend = kd; m_state = 1; m_age = 0;
            end
         end
         1: begin
            m_age++;
            due = (m_age % P) == 0;
            case (m_pend)
               0:       begin pos = int'(head_x) + SS; lo = 2; hi = 639; end
               1:       begin pos = int'(head_x) - SS; lo = 2; hi = 639; end
               2:       begin pos = int'(head_y) + SS; lo = 2; hi = 479; end
               default: begin pos = int'(head_y) - SS; lo = 2; hi = 479; end
            endcase
            fatal = due && ((pos + hs >= hi) || (pos - hs <= lo));
            if (fatal) begin
               m_state = 2; m_go = 1; m_mx = 0; m_my = 0;
            end else begin
               ref_dir = due ? m_pend : m_dir;
               if (due) begin
                  m_dir  = m_pend;
                  m_step = 1;
                  m_mx = (m_pend == 0) ? SS : (m_pend == 1) ? -SS : 0;
                  m_my = (m_pend == 2) ? SS : (m_pend == 3) ? -SS : 0;
               end
               if (kd >= 0 && ((kd < 2) != (ref_dir < 2))) m_pend = kd;
               if (food_hit && !m_prev_hit) begin
                  m_grow   = 1;
                  m_score  = (m_score < 255) ? m_score + 1 : 255;
                  m_score2 = (m_score2 < 3) ? m_score2 + 1 : 3;
               end
            end
         end
         default: begin
            if (keycode == 8'h2C) begin
               m_state = 0; m_score = 0; m_score2 = 0; m_go = 0; m_dir = 0; m_pend = 0;
            end
         end
      endcase
      m_prev_hit = food_hit;
   endtask

   task automatic advance();
      model_edge();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; keycode = 8'h00; food_hit = 1'b0;
      head_x = 10'd320; head_y = 10'd240; head_s = 10'd10;
      model_reset();
      #3;
      total++;
      if (got_vec() !== exp_vec()) begin
         bad++; $display("FAIL reset_async got=%h want=%h", got_vec(), exp_vec());
      end
      @(posedge frame_clk); #1;
      total++;
      if (got_vec() !== exp_vec()) begin
         bad++; $display("FAIL reset_hold got=%h want=%h", got_vec(), exp_vec());
      end
      Reset = 1'b0;
   endtask

   task automatic test_start();
      logic exp_step;
      keycode = 8'h07;
      for (int i = 1; i <= 14; i++) begin
         advance();
         exp_step = (i >= 5) && ((i - 5) % 4 == 0);
         total++;
         if (got_vec() !== exp_vec() || step !== exp_step || state !== 2'd1 ||
             (exp_step && motion_x !== 10'd4)) begin
            bad++;
            $display("FAIL start cycle=%0d got=%h want=%h step=%b want_step=%b",
                     i, got_vec(), exp_vec(), step, exp_step);
         end
      end
   endtask

   task automatic test_turn();
      int n;
      keycode = 8'h04;
      advance();
      total++;
      if (got_vec() !== exp_vec() || dir !== 2'd0) begin
         bad++; $display("FAIL turn_reverse got=%h want=%h", got_vec(), exp_vec());
      end
      keycode = 8'h1A;
      n = 0;
      do begin
         advance();
         n++;
         total++;
         if (got_vec() !== exp_vec()) begin
            bad++; $display("FAIL turn_wait got=%h want=%h", got_vec(), exp_vec());
         end
      end while (m_step == 0 && n < 10);
      total++;
      if (step !== 1'b1 || dir !== 2'd3 || motion_y !== 10'h3FC || motion_x !== 10'd0) begin
         bad++;
         $display("FAIL turn_up step=%b dir=%0d mx=%h my=%h want step=1 dir=3 mx=000 my=3fc",
                  step, dir, motion_x, motion_y);
      end
   endtask

   task automatic test_wall();
      #2 Reset = 1'b1;
      #1 Reset = 1'b0;
      model_reset();
      keycode = 8'h07; head_x = 10'd585; head_y = 10'd240; head_s = 10'd50;
      for (int i = 0; i < 6; i++) begin
         advance();
         total++;
         if (got_vec() !== exp_vec()) begin
            bad++; $display("FAIL wall cycle=%0d got=%h want=%h", i, got_vec(), exp_vec());
         end
      end
      total++;
      if (state !== 2'd2 || game_over !== 1'b1 || step !== 1'b0 ||
          motion_x !== 10'd0 || motion_y !== 10'd0) begin
         bad++;
         $display("FAIL wall_dead state=%0d go=%b step=%b mx=%h want state=2 go=1 step=0 mx=0",
                  state, game_over, step, motion_x);
      end
   endtask

   task automatic test_dead();
      keycode = 8'h1A;
      for (int i = 0; i < 3; i++) begin
         advance();
         total++;
         if (got_vec() !== exp_vec() || state !== 2'd2) begin
            bad++; $display("FAIL dead_wasd got=%h want=%h", got_vec(), exp_vec());
         end
      end
      keycode = 8'h2C;
      advance();
      total++;
      if (got_vec() !== exp_vec() || state !== 2'd0 || game_over !== 1'b0 || score !== 8'd0) begin
         bad++; $display("FAIL dead_space got=%h want=%h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_food();
      head_x = 10'd320; head_y = 10'd240; head_s = 10'd10;
      keycode = 8'h07;
      advance();
      keycode = 8'h00;
      for (int p = 0; p < 5; p++) begin
         for (int c = 0; c < 6; c++) begin
            food_hit = (c < 3);
            advance();
            total++;
            if (got_vec() !== exp_vec()) begin
               bad++;
               $display("FAIL food pulse=%0d cycle=%0d got=%h want=%h", p, c, got_vec(), exp_vec());
            end
         end
      end
      total++;
      if (score !== 8'd5 || score2 !== 2'd3) begin
         bad++; $display("FAIL food_count score=%0d score2=%0d want 5 and 3", score, score2);
      end
   endtask

   task automatic test_food_wall();
      int n;
      food_hit = 1'b0;
      n = 0;
      while (!(m_state == 1 && ((m_age + 1) % P) == 0) && n < 10) begin
         advance();
         n++;
      end
      total++;
      if (n >= 10) begin
         bad++; $display("FAIL food_wall_align timeout state=%0d want 1", state);
      end
      food_hit = 1'b1; head_x = 10'd585; head_s = 10'd50;
      advance();
      total++;
      if (got_vec() !== exp_vec() || grow !== 1'b0 || state !== 2'd2 || score !== 8'd5) begin
         bad++;
         $display("FAIL food_wall got=%h want=%h grow=%b score=%0d", got_vec(), exp_vec(), grow, score);
      end
      food_hit = 1'b0; keycode = 8'h2C;
      advance();
      total++;
      if (got_vec() !== exp_vec() || score !== 8'd0) begin
         bad++; $display("FAIL space_clears got=%h want=%h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 9))
            0: keycode = 8'h04;
            1: keycode = 8'h07;
            2: keycode = 8'h16;
            3: keycode = 8'h1A;
            4: keycode = 8'h2C;
            5: keycode = 8'($urandom);
            default: keycode = 8'h00;
         endcase
         food_hit = ($urandom_range(0, 3) == 0);
         head_s = 10'($urandom_range(1, 30));
         if ($urandom_range(0, 15) == 0) begin
            head_x = 10'($urandom_range(0, 700));
            head_y = 10'($urandom_range(0, 520));
         end else begin
            head_x = 10'($urandom_range(60, 580));
            head_y = 10'($urandom_range(60, 420));
         end
         advance();
         total++;
         if (got_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL random i=%0d key=%h got=%h want=%h", i, keycode, got_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid_step();
      int n;
      head_x = 10'd320; head_y = 10'd240; head_s = 10'd10; food_hit = 1'b0;
      keycode = 8'h2C;
      advance();
      keycode = 8'h16;
      n = 0;
      do begin
         advance();
         n++;
      end while (m_step == 0 && n < 16);
      total++;
      if (got_vec() !== exp_vec() || step !== 1'b1) begin
         bad++; $display("FAIL pre_reset_step got=%h want=%h", got_vec(), exp_vec());
      end
      #2 Reset = 1'b1;
      #1;
      model_reset();
      total++;
      if (got_vec() !== exp_vec() || step !== 1'b0) begin
         bad++; $display("FAIL reset_mid_step got=%h want=%h", got_vec(), exp_vec());
      end
      #1 Reset = 1'b0;
      advance();
      total++;
      if (got_vec() !== exp_vec()) begin
         bad++; $display("FAIL after_reset got=%h want=%h", got_vec(), exp_vec());
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_turn();
      test_wall();
      test_dead();
      test_food();
      test_food_wall();
      test_random();
      test_reset_mid_step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
